// File: rtl/calendar_set_ctrl.sv
// Set/run sequencer for the calendar: debounces the mode/inc buttons, walks the
// SET states, generates field increment pulses and gates/replays hour ticks.
module calendar_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES  = 50,
    parameter int PEND_MAX        = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       hour_tick,
    output logic       hour_enable,
    output logic       day_increment,
    output logic       month_increment,
    output logic       year_increment,
    output logic [1:0] mode
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW   = $clog2(PEND_MAX + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_YEAR  = 2'd1,
        SET_MONTH = 2'd2,
        SET_DAY   = 2'd3
    } state_t;

    // Bit 0 carries the mode button, bit 1 the inc button.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d, rise_q, rise_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];

    state_t        state_q, state_d;
    logic          armed_q, armed_d, repeating_q, repeating_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          hour_q, hour_d, day_q, day_d, month_q, month_d, year_q, year_d;
    logic          mode_rise, inc_rise, inc_held, fire;

    always_comb begin
        sync1_d = {btn_inc, btn_mode};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        rise_d  = '0;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES)) begin
                    deb_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign mode_rise = rise_q[0];
    assign inc_rise  = rise_q[1];
    assign inc_held  = deb_q[1];
    assign fire = armed_q && inc_held &&
                  (rcnt_q == (repeating_q ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1)));

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q & inc_held;
        repeating_d = repeating_q;
        rcnt_d      = (armed_q && rcnt_q != RW'(RMAX)) ? rcnt_q + RW'(1) : rcnt_q;
        if (state_q == RUN) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = (tcnt_q == TW'(TIMEOUT_CYCLES)) ? tcnt_q : tcnt_q + TW'(1);
        end
        day_d   = 1'b0;
        month_d = 1'b0;
        year_d  = 1'b0;
        // A mode rise always wins: any inc rise in the same cycle is discarded.
        if (mode_rise) begin
            case (state_q)
                RUN:       state_d = SET_YEAR;
                SET_YEAR:  state_d = SET_MONTH;
                SET_MONTH: state_d = SET_DAY;
                default:   state_d = RUN;
            endcase
            armed_d = 1'b0;
            tcnt_d  = '0;
        end else if (state_q != RUN) begin
            if (inc_rise || fire) begin
                year_d      = (state_q == SET_YEAR);
                month_d     = (state_q == SET_MONTH);
                day_d       = (state_q == SET_DAY);
                armed_d     = 1'b1;
                repeating_d = !inc_rise;
                rcnt_d      = '0;
                tcnt_d      = '0;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = RUN;
                armed_d = 1'b0;
            end
        end
    end

    // Ticks swallowed while editing are replayed back-to-back once RUN resumes.
    always_comb begin
        hour_d = 1'b0;
        pend_d = pend_q;
        if (state_q == RUN) begin
            hour_d = hour_tick | (pend_q != '0);
            if (!hour_tick && pend_q != '0) pend_d = pend_q - PW'(1);
        end else if (hour_tick && pend_q != PW'(PEND_MAX)) begin
            pend_d = pend_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            rise_q      <= '0;
            dcnt_q[0]   <= '0;
            dcnt_q[1]   <= '0;
            state_q     <= RUN;
            armed_q     <= 1'b0;
            repeating_q <= 1'b0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            pend_q      <= '0;
            hour_q      <= 1'b0;
            day_q       <= 1'b0;
            month_q     <= 1'b0;
            year_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            rise_q      <= rise_d;
            dcnt_q[0]   <= dcnt_d[0];
            dcnt_q[1]   <= dcnt_d[1];
            state_q     <= state_d;
            armed_q     <= armed_d;
            repeating_q <= repeating_d;
            rcnt_q      <= rcnt_d;
            tcnt_q      <= tcnt_d;
            pend_q      <= pend_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
        end
    end

    assign hour_enable     = hour_q;
    assign day_increment   = day_q;
    assign month_increment = month_q;
    assign year_increment  = year_q;
    assign mode            = state_q;
endmodule
